// File: rtl/zynet_pkg.sv
// Shared constants for the zynet host bus: register map, AXI response codes,
// bus FSM state types and the default weight/bias word width.
package zynet_pkg;

   localparam int unsigned DATA_WIDTH = 16;

   localparam logic [31:0] REG_WEIGHT  = 32'h0000_0000;
   localparam logic [31:0] REG_BIAS    = 32'h0000_0004;
   localparam logic [31:0] REG_RESULT  = 32'h0000_0008;
   localparam logic [31:0] REG_LAYER   = 32'h0000_000C;
   localparam logic [31:0] REG_NEURON  = 32'h0000_0010;
   localparam logic [31:0] REG_STATUS  = 32'h0000_0014;
   localparam logic [31:0] REG_SOFTRST = 32'h0000_001C;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;

   // Full-address match: odd offsets and anything past 0x1C fall through.
   function automatic logic reg_mapped(input logic [31:0] addr);
      case (addr)
         REG_WEIGHT, REG_BIAS, REG_RESULT, REG_LAYER,
         REG_NEURON, REG_STATUS, REG_SOFTRST: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/zynet_axil_slave_if.sv
// AXI4-Lite host bus (32-bit address/data) between the zynet top and its
// configuration slave.
interface zynet_axil_slave_if;

   logic [31:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [31:0] s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
             s_axi_araddr, s_axi_arvalid, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );

   modport master (
      output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
             s_axi_araddr, s_axi_arvalid, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );

endinterface

// File: rtl/zynet_axil_slave.sv
// AXI4-Lite configuration/readout slave for zynet: weight/bias load strobes,
// layer/neuron select, soft reset and result capture. ZYNET_INTR_EN drives intr.
module zynet_axil_slave
   import zynet_pkg::*;
#(
   parameter int unsigned dataWidth   = DATA_WIDTH,
   parameter int unsigned layerWidth  = 8,
   parameter int unsigned neuronWidth = 16,
   parameter int unsigned resultWidth = 32
) (
   input  logic                   s_axi_aclk,
   input  logic                   s_axi_areset,
   zynet_axil_slave_if.slave      s_axi,
   input  logic [resultWidth-1:0] result_data,
   input  logic                   result_valid,
   output logic                   weight_valid,
   output logic [dataWidth-1:0]   weight_data,
   output logic                   bias_valid,
   output logic [dataWidth-1:0]   bias_data,
   output logic [layerWidth-1:0]  layer_sel,
   output logic [neuronWidth-1:0] neuron_sel,
   output logic                   soft_reset,
   output logic                   intr
);

   wr_state_t              w_state, w_state_nxt;
   rd_state_t              r_state, r_state_nxt;
   logic                   w_accept, b_valid;
   logic                   ar_accept, r_valid;
   logic [1:0]             b_resp, r_resp;
   logic [31:0]            r_data, rd_mux;
   logic                   rd_is_result;
   logic [resultWidth-1:0] result_q;
   logic                   pending;
   logic                   unused_wdata;

   assign unused_wdata = ^s_axi.s_axi_wdata;

   always_comb begin
      w_state_nxt = w_state;
      w_accept    = 1'b0;
      b_valid     = 1'b0;
      case (w_state)
         W_IDLE: if (s_axi.s_axi_awvalid && s_axi.s_axi_wvalid) w_state_nxt = W_ACK;
         W_ACK: begin
            w_accept    = 1'b1;
            w_state_nxt = W_RESP;
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (s_axi.s_axi_bready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_nxt = r_state;
      ar_accept   = 1'b0;
      r_valid     = 1'b0;
      case (r_state)
         R_IDLE: if (s_axi.s_axi_arvalid) r_state_nxt = R_ACK;
         R_ACK: begin
            ar_accept   = 1'b1;
            r_state_nxt = R_DATA;
         end
         R_DATA: begin
            r_valid = 1'b1;
            if (s_axi.s_axi_rready) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (s_axi.s_axi_araddr)
         REG_RESULT:  rd_mux[resultWidth-1:0] = result_q;
         REG_LAYER:   rd_mux[layerWidth-1:0]  = layer_sel;
         REG_NEURON:  rd_mux[neuronWidth-1:0] = neuron_sel;
         REG_STATUS:  rd_mux[1:0]             = {soft_reset, pending};
         REG_SOFTRST: rd_mux[0]               = soft_reset;
         default:     rd_mux                  = '0;
      endcase
   end

   // Write side: register update and one-cycle strobes land on the W_ACK edge.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         w_state      <= W_IDLE;
         b_resp       <= RESP_OKAY;
         weight_valid <= 1'b0;
         weight_data  <= '0;
         bias_valid   <= 1'b0;
         bias_data    <= '0;
         layer_sel    <= '0;
         neuron_sel   <= '0;
         soft_reset   <= 1'b1;
      end else begin
         w_state      <= w_state_nxt;
         weight_valid <= 1'b0;
         bias_valid   <= 1'b0;
         if (w_accept) begin
            b_resp <= reg_mapped(s_axi.s_axi_awaddr) ? RESP_OKAY : RESP_SLVERR;
            case (s_axi.s_axi_awaddr)
               REG_WEIGHT: begin
                  weight_valid <= 1'b1;
                  weight_data  <= s_axi.s_axi_wdata[dataWidth-1:0];
               end
               REG_BIAS: begin
                  bias_valid <= 1'b1;
                  bias_data  <= s_axi.s_axi_wdata[dataWidth-1:0];
               end
               REG_LAYER:   layer_sel  <= s_axi.s_axi_wdata[layerWidth-1:0];
               REG_NEURON:  neuron_sel <= s_axi.s_axi_wdata[neuronWidth-1:0];
               REG_SOFTRST: soft_reset <= s_axi.s_axi_wdata[0];
               default: ;
            endcase
         end
      end
   end

   // Read side: data is snapshotted at the AR handshake and held through R_DATA.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         r_state      <= R_IDLE;
         r_data       <= '0;
         r_resp       <= RESP_OKAY;
         rd_is_result <= 1'b0;
         result_q     <= '0;
         pending      <= 1'b0;
      end else begin
         r_state <= r_state_nxt;
         if (ar_accept) begin
            r_data       <= rd_mux;
            r_resp       <= reg_mapped(s_axi.s_axi_araddr) ? RESP_OKAY : RESP_SLVERR;
            rd_is_result <= (s_axi.s_axi_araddr == REG_RESULT);
         end
         // A fresh capture outranks a same-cycle RESULT read clear.
         if (result_valid) begin
            result_q <= result_data;
            pending  <= 1'b1;
         end else if (r_valid && s_axi.s_axi_rready && rd_is_result) begin
            pending <= 1'b0;
         end
      end
   end

   assign s_axi.s_axi_awready = w_accept;
   assign s_axi.s_axi_wready  = w_accept;
   assign s_axi.s_axi_bvalid  = b_valid;
   assign s_axi.s_axi_bresp   = b_resp;
   assign s_axi.s_axi_arready = ar_accept;
   assign s_axi.s_axi_rvalid  = r_valid;
   assign s_axi.s_axi_rdata   = r_data;
   assign s_axi.s_axi_rresp   = r_resp;

`ifdef ZYNET_INTR_EN
   assign intr = pending;
`else
   assign intr = 1'b0;
`endif

endmodule

// File: tb/tb_zynet_axil_slave.sv
// Directed bench for zynet_axil_slave with a per-cycle register-map model.
module tb_zynet_axil_slave;

`ifdef ZYNET_INTR_EN
   localparam bit INTR_EN = 1'b1;
`else
   localparam bit INTR_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] result_data;
   logic        result_valid;
   logic        weight_valid, bias_valid, soft_reset, intr;
   logic [15:0] weight_data, bias_data, neuron_sel;
   logic [7:0]  layer_sel;

   int n_tests = 0;
   int n_fail  = 0;

   zynet_axil_slave_if s_axi ();

   zynet_axil_slave #(
      .dataWidth   (16),
      .layerWidth  (8),
      .neuronWidth (16),
      .resultWidth (32)
   ) dut (
      .s_axi_aclk   (clk),
      .s_axi_areset (rst),
      .s_axi        (s_axi),
      .result_data  (result_data),
      .result_valid (result_valid),
      .weight_valid (weight_valid),
      .weight_data  (weight_data),
      .bias_valid   (bias_valid),
      .bias_data    (bias_data),
      .layer_sel    (layer_sel),
      .neuron_sel   (neuron_sel),
      .soft_reset   (soft_reset),
      .intr         (intr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Register-map model: state for the current cycle, advanced from what the
   // bus will commit at the coming edge.
   logic [7:0]  m_layer;
   logic [15:0] m_neuron, m_wd, m_bd;
   logic        m_soft, m_pending, m_wv, m_bv, m_rd_result, m_live = 1'b0;
   logic [31:0] m_result, m_rdata;
   logic [1:0]  m_rresp, m_bresp;

   always @(negedge clk) begin
      logic old_rd_result;
      if (m_live && !rst) begin
         chk("layer_sel", layer_sel, m_layer);
         chk("neuron_sel", neuron_sel, m_neuron);
         chk("soft_reset", soft_reset, m_soft);
         chk("intr", intr, m_pending & INTR_EN);
         chk("weight_valid", weight_valid, m_wv);
         chk("bias_valid", bias_valid, m_bv);
         if (m_wv) chk("weight_data", weight_data, m_wd);
         if (m_bv) chk("bias_data", bias_data, m_bd);
         if (s_axi.s_axi_bvalid) chk("bresp", s_axi.s_axi_bresp, m_bresp);
         if (s_axi.s_axi_rvalid) begin
            chk("rdata", s_axi.s_axi_rdata, m_rdata);
            chk("rresp", s_axi.s_axi_rresp, m_rresp);
         end
         if (s_axi.s_axi_awready)
            chk("aw_needs_both", s_axi.s_axi_awvalid && s_axi.s_axi_wvalid, 1);
      end
      if (rst) begin
         m_layer = '0; m_neuron = '0; m_soft = 1'b1; m_pending = 1'b0; m_result = '0;
         m_wv = 1'b0; m_bv = 1'b0; m_rd_result = 1'b0; m_live = 1'b1;
      end else begin
         m_wv = 1'b0;
         m_bv = 1'b0;
         old_rd_result = m_rd_result;
         if (s_axi.s_axi_arvalid && s_axi.s_axi_arready) begin
            m_rd_result = (s_axi.s_axi_araddr == 32'h08);
            m_rdata = 32'h0;
            m_rresp = 2'b00;
            case (s_axi.s_axi_araddr)
               32'h00, 32'h04: m_rdata = 32'h0;
               32'h08: m_rdata = m_result;
               32'h0C: m_rdata = {24'h0, m_layer};
               32'h10: m_rdata = {16'h0, m_neuron};
               32'h14: m_rdata = {30'h0, m_soft, m_pending};
               32'h1C: m_rdata = {31'h0, m_soft};
               default: m_rresp = 2'b10;
            endcase
         end
         if (s_axi.s_axi_awvalid && s_axi.s_axi_awready && s_axi.s_axi_wvalid && s_axi.s_axi_wready) begin
            m_bresp = 2'b00;
            case (s_axi.s_axi_awaddr)
               32'h00: begin m_wv = 1'b1; m_wd = s_axi.s_axi_wdata[15:0]; end
               32'h04: begin m_bv = 1'b1; m_bd = s_axi.s_axi_wdata[15:0]; end
               32'h0C: m_layer  = s_axi.s_axi_wdata[7:0];
               32'h10: m_neuron = s_axi.s_axi_wdata[15:0];
               32'h1C: m_soft   = s_axi.s_axi_wdata[0];
               32'h08, 32'h14: ;
               default: m_bresp = 2'b10;
            endcase
         end
         if (result_valid) begin
            m_result  = result_data;
            m_pending = 1'b1;
         end else if (s_axi.s_axi_rvalid && s_axi.s_axi_rready && old_rd_result) begin
            m_pending = 1'b0;
         end
      end
   end

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input int w_delay, input int b_delay,
                            output logic [1:0] resp, output logic wv, output logic [15:0] wd,
                            output logic bv, output logic [15:0] bd, output logic sr);
      int n;
      @(posedge clk); #1;
      s_axi.s_axi_awaddr  = addr;
      s_axi.s_axi_awvalid = 1'b1;
      s_axi.s_axi_wdata   = data;
      s_axi.s_axi_bready  = (b_delay == 0);
      for (int i = 0; i < w_delay; i++) begin
         @(negedge clk);
         chk("aw_alone", s_axi.s_axi_awready, 0);
         @(posedge clk); #1;
      end
      s_axi.s_axi_wvalid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!s_axi.s_axi_awready && n < 20);
      chk("aw_latency", n, 2);
      chk("wready", s_axi.s_axi_wready, 1);
      @(posedge clk); #1;
      s_axi.s_axi_awvalid = 1'b0;
      s_axi.s_axi_wvalid  = 1'b0;
      @(negedge clk);
      chk("b_latency", s_axi.s_axi_bvalid, 1);
      wv = weight_valid; wd = weight_data; bv = bias_valid; bd = bias_data; sr = soft_reset;
      for (int i = 0; i < b_delay; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("b_hold", s_axi.s_axi_bvalid, 1);
      end
      if (b_delay > 0) begin
         @(posedge clk); #1;
         s_axi.s_axi_bready = 1'b1;
         @(negedge clk);
      end
      resp = s_axi.s_axi_bresp;
      @(posedge clk); #1;
      s_axi.s_axi_bready = 1'b0;
      @(negedge clk);
      chk("b_done", s_axi.s_axi_bvalid, 0);
   endtask

   task automatic axi_read(input logic [31:0] addr, input bit pulse, input logic [31:0] pdata,
                           output logic [31:0] d, output logic [1:0] r);
      int n;
      @(posedge clk); #1;
      s_axi.s_axi_araddr  = addr;
      s_axi.s_axi_arvalid = 1'b1;
      s_axi.s_axi_rready  = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!s_axi.s_axi_arready && n < 20);
      chk("ar_latency", n, 2);
      @(posedge clk); #1;
      s_axi.s_axi_arvalid = 1'b0;
      if (pulse) begin
         result_valid = 1'b1;
         result_data  = pdata;
      end
      @(negedge clk);
      chk("r_latency", s_axi.s_axi_rvalid, 1);
      d = s_axi.s_axi_rdata;
      r = s_axi.s_axi_rresp;
      @(posedge clk); #1;
      s_axi.s_axi_rready = 1'b0;
      result_valid       = 1'b0;
      @(negedge clk);
      chk("r_done", s_axi.s_axi_rvalid, 0);
   endtask

   task automatic pulse_result(input logic [31:0] d);
      @(posedge clk); #1;
      result_valid = 1'b1;
      result_data  = d;
      @(posedge clk); #1;
      result_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, d2;
      logic [1:0]  r, resp;
      logic        wv, bv, sr;
      logic [15:0] wd, bd;

      rst = 1'b1;
      result_valid = 1'b0; result_data = '0;
      s_axi.s_axi_awaddr = '0; s_axi.s_axi_awvalid = 1'b0;
      s_axi.s_axi_wdata  = '0; s_axi.s_axi_wvalid  = 1'b0;
      s_axi.s_axi_bready = 1'b0;
      s_axi.s_axi_araddr = '0; s_axi.s_axi_arvalid = 1'b0;
      s_axi.s_axi_rready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_soft_reset", soft_reset, 1);
      chk("rst_awready", s_axi.s_axi_awready, 0);
      chk("rst_bvalid", s_axi.s_axi_bvalid, 0);
      chk("rst_arready", s_axi.s_axi_arready, 0);
      chk("rst_rvalid", s_axi.s_axi_rvalid, 0);
      chk("rst_rdata", s_axi.s_axi_rdata, 0);
      chk("rst_intr", intr, 0);
      chk("rst_layer", layer_sel, 0);
      chk("rst_weight_valid", weight_valid, 0);

      // soft reset release
      axi_read(32'h1C, 1'b0, 0, d, r);
      chk("softrst_rd", d, 32'h1);
      chk("softrst_rresp", r, 2'b00);
      axi_write(32'h1C, 32'h0, 0, 0, resp, wv, wd, bv, bd, sr);
      chk("softrst_bresp", resp, 2'b00);
      chk("softrst_fall", sr, 0);
      axi_read(32'h14, 1'b0, 0, d, r);
      chk("status_clear", d, 32'h0);

      // select and strobes
      axi_write(32'h0C, 32'h3, 0, 0, resp, wv, wd, bv, bd, sr);
      axi_write(32'h10, 32'd17, 0, 0, resp, wv, wd, bv, bd, sr);
      axi_write(32'h00, 32'h0000_1A2B, 0, 0, resp, wv, wd, bv, bd, sr);
      chk("layer_lit", layer_sel, 3);
      chk("neuron_lit", neuron_sel, 17);
      chk("weight_pulse", wv, 1);
      chk("weight_word", wd, 16'h1A2B);
      chk("weight_no_bias", bv, 0);
      axi_write(32'h04, 32'hCAFE_BEEF, 0, 0, resp, wv, wd, bv, bd, sr);
      chk("bias_pulse", bv, 1);
      chk("bias_word", bd, 16'hBEEF);
      chk("bias_no_weight", wv, 0);
      axi_read(32'h00, 1'b0, 0, d, r);
      chk("weight_rd_zero", d, 0);
      axi_read(32'h0C, 1'b0, 0, d, r);
      chk("layer_rd", d, 3);

      // result capture and read-clear
      pulse_result(32'd7);
      @(negedge clk);
      chk("intr_set", intr, INTR_EN);
      axi_read(32'h14, 1'b0, 0, d, r);
      chk("status_pending", d, 32'h1);
      axi_read(32'h08, 1'b0, 0, d, r);
      chk("result_rd", d, 7);
      chk("intr_clear", intr, 0);
      axi_read(32'h14, 1'b0, 0, d, r);
      chk("status_cleared", d, 32'h0);

      // capture coinciding with the clearing read
      pulse_result(32'd9);
      axi_read(32'h08, 1'b1, 32'd5, d, r);
      chk("coinc_old", d, 9);
      chk("coinc_intr", intr, INTR_EN);
      axi_read(32'h14, 1'b0, 0, d, r);
      chk("coinc_pending", d, 32'h1);
      axi_read(32'h08, 1'b0, 0, d, r);
      chk("coinc_new", d, 5);

      // unmapped and misaligned
      axi_write(32'h18, 32'hFFFF_FFFF, 0, 0, resp, wv, wd, bv, bd, sr);
      chk("unmap_bresp", resp, 2'b10);
      chk("unmap_no_strobe", {wv, bv}, 0);
      axi_write(32'h0E, 32'h77, 0, 0, resp, wv, wd, bv, bd, sr);
      chk("odd_bresp", resp, 2'b10);
      chk("odd_layer_kept", layer_sel, 3);
      axi_read(32'h24, 1'b0, 0, d, r);
      chk("unmap_rdata", d, 0);
      chk("unmap_rresp", r, 2'b10);
      axi_read(32'h02, 1'b0, 0, d, r);
      chk("odd_rresp", r, 2'b10);

      // lone AW, delayed bready, concurrent read
      fork
         axi_write(32'h10, 32'h0000_0055, 10, 4, resp, wv, wd, bv, bd, sr);
         begin
            repeat (14) @(posedge clk);
            axi_read(32'h0C, 1'b0, 0, d2, r);
         end
      join
      chk("late_w_bresp", resp, 2'b00);
      chk("late_w_neuron", neuron_sel, 16'h55);
      chk("concurrent_rd", d2, 3);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
